// File: rtl/led_seq.sv
// ---------------------------------------------------------------------------
// led_seq -- colour-sequence engine and bus arbiter for the LED PWM port.
//
// The CPU loads a table of up to 8 RGB steps (4 bytes per step:
// {R, G, B, HOLD}) through a small register window. When running, the
// engine writes the three LED PWM duty registers (addr 1/2/3) on three
// consecutive cycles, then holds the colour for HOLD prescaled ticks before
// moving to the next step. All LED PWM register traffic passes through the
// arbiter here; a CPU access always wins and the engine retries its write.
//
// Bus handshake: a CPU access to the LED PWM block is a single-cycle
// qualifier (cpu_led_cs_i) with no back-pressure; it is forwarded on the
// same cycle. The engine's own writes are single-cycle strobes on led_cs_o
// with led_we_o=1 and complete whenever no CPU access is present.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cs_i             select for the sequencer register window
//   we_i             write enable (shared CPU bus)
//   addr_i[3:0]      register select (shared CPU bus)
//   din_i[7:0]       write data (shared CPU bus)
//   dout_o[7:0]      registered read data (valid the cycle after a read)
//   cpu_led_cs_i     CPU select for the LED PWM block
//   led_cs_o         LED PWM cs
//   led_we_o         LED PWM we
//   led_addr_o[3:0]  LED PWM register address
//   led_din_o[7:0]   LED PWM write data
//   busy_o           high whenever the engine is not idle
//   dbg_state_o[2:0] current engine state (debug observation)
//
// Register window (cs_i=1):
//   0x0 CTRL   [0] run, [1] loop; reads {busy, 5'b0, loop, run}
//   0x1 LEN    [2:0]; sequence has LEN+1 steps
//   0x2 PRESC_L, 0x3 PRESC_H
//   0x4 PTR    [4:0] table byte pointer
//   0x5 DATA   table[PTR]; every access post-increments PTR (wraps 31->0)
//   0x6 STEP   read-only current step index
// ---------------------------------------------------------------------------
module led_seq #(
    parameter int PW = 16  // prescaler width, must be <= 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_i,
    input  logic       we_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    input  logic       cpu_led_cs_i,
    output logic       led_cs_o,
    output logic       led_we_o,
    output logic [3:0] led_addr_o,
    output logic [7:0] led_din_o,
    output logic       busy_o,
    output logic [2:0] dbg_state_o
);

    // Register addresses
    localparam logic [3:0] A_CTRL    = 4'h0;
    localparam logic [3:0] A_LEN     = 4'h1;
    localparam logic [3:0] A_PRESC_L = 4'h2;
    localparam logic [3:0] A_PRESC_H = 4'h3;
    localparam logic [3:0] A_PTR     = 4'h4;
    localparam logic [3:0] A_DATA    = 4'h5;
    localparam logic [3:0] A_STEP    = 4'h6;

    // LED PWM duty register addresses
    localparam logic [3:0] L_RED     = 4'h1;
    localparam logic [3:0] L_GREEN   = 4'h2;
    localparam logic [3:0] L_BLUE    = 4'h3;

    // Engine states
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR_R = 3'd1;
    localparam logic [2:0] S_WR_G = 3'd2;
    localparam logic [2:0] S_WR_B = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic          run_q, run_d;
    logic          loop_q, loop_d;
    logic [2:0]    len_q, len_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    ptr_q, ptr_d;
    logic [2:0]    step_q, step_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    dout_q, dout_d;

    // Colour table, not reset: contents are whatever the CPU loaded.
    logic [7:0]    table_mem [0:31];

    // -----------------------------------------------------------------------
    // Decode and helpers
    // -----------------------------------------------------------------------
    logic          reg_wr;
    logic          reg_rd;
    logic          tbl_wr;
    logic          busy;
    logic          in_wr;
    logic          stall;
    logic          tick;
    logic          hold_done;
    logic          seq_clear_run;
    logic [15:0]   presc_ext;
    logic [15:0]   presc_new;
    logic [7:0]    rd_data;
    logic [4:0]    fetch_idx;
    logic [7:0]    fetch_byte;
    logic [7:0]    hold_byte;
    logic [3:0]    wr_addr;

    assign reg_wr    = cs_i & we_i;
    assign reg_rd    = cs_i & ~we_i;
    assign tbl_wr    = reg_wr & (addr_i == A_DATA);
    assign busy      = (state_q != S_IDLE);
    assign in_wr     = (state_q == S_WR_R) || (state_q == S_WR_G) ||
                       (state_q == S_WR_B);
    // A CPU access to the LED block takes the bus; the engine holds its state
    // so the write it wanted to make is retried on the next free cycle.
    assign stall     = cpu_led_cs_i;

    // PRESC is kept PW bits wide but always presented as two bytes.
    assign presc_ext = 16'(presc_q);

    // Prescaler wraps after reaching PRESC, so PRESC=0 ticks every cycle.
    assign tick      = (pcnt_q == presc_q);
    // The tick that would take the hold count to zero ends the hold at once,
    // so HOLD=H lasts exactly H ticks and HOLD=0 leaves on the first cycle.
    assign hold_done = (hold_q == 8'd0) || (tick && (hold_q == 8'd1));

    // -----------------------------------------------------------------------
    // Table fetch for the current write state
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_idx = {step_q, 2'b00};
        wr_addr   = 4'h0;
        unique case (state_q)
            S_WR_R: begin
                fetch_idx = {step_q, 2'b00};
                wr_addr   = L_RED;
            end
            S_WR_G: begin
                fetch_idx = {step_q, 2'b01};
                wr_addr   = L_GREEN;
            end
            S_WR_B: begin
                fetch_idx = {step_q, 2'b10};
                wr_addr   = L_BLUE;
            end
            default: begin
                fetch_idx = {step_q, 2'b00};
                wr_addr   = 4'h0;
            end
        endcase
    end

    assign fetch_byte = table_mem[fetch_idx];
    assign hold_byte  = table_mem[{step_q, 2'b11}];

    // -----------------------------------------------------------------------
    // Engine next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        pcnt_d        = pcnt_q;
        hold_d        = hold_q;
        seq_clear_run = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                hold_d = 8'd0;
                if (run_q) begin
                    state_d = S_WR_R;
                    step_d  = 3'd0;
                end
            end

            S_WR_R: begin
                pcnt_d = '0;
                hold_d = 8'd0;
                if (!stall) begin
                    state_d = S_WR_G;
                end
            end

            S_WR_G: begin
                pcnt_d = '0;
                hold_d = 8'd0;
                if (!stall) begin
                    state_d = S_WR_B;
                end
            end

            S_WR_B: begin
                pcnt_d = '0;
                hold_d = 8'd0;
                if (!stall) begin
                    // A stop request seen during the triplet takes effect
                    // only here, so a partial colour is never left behind.
                    if (run_q) begin
                        state_d = S_HOLD;
                        hold_d  = hold_byte;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_HOLD: begin
                if (!run_q) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                    hold_d  = 8'd0;
                end else if (hold_done) begin
                    pcnt_d = '0;
                    hold_d = 8'd0;
                    if (step_q < len_q) begin
                        step_d  = step_q + 3'd1;
                        state_d = S_WR_R;
                    end else if (loop_q) begin
                        step_d  = 3'd0;
                        state_d = S_WR_R;
                    end else begin
                        seq_clear_run = 1'b1;
                        state_d       = S_IDLE;
                    end
                end else if (tick) begin
                    hold_d = hold_q - 8'd1;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                pcnt_d  = '0;
                hold_d  = 8'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register window: writes and registered reads
    // -----------------------------------------------------------------------
    always_comb begin
        unique case (addr_i)
            A_CTRL:    rd_data = {busy, 5'b0, loop_q, run_q};
            A_LEN:     rd_data = {5'b0, len_q};
            A_PRESC_L: rd_data = presc_ext[7:0];
            A_PRESC_H: rd_data = presc_ext[15:8];
            A_PTR:     rd_data = {3'b0, ptr_q};
            A_DATA:    rd_data = table_mem[ptr_q];
            A_STEP:    rd_data = {5'b0, step_q};
            default:   rd_data = 8'h00;
        endcase
    end

    always_comb begin
        run_d     = run_q;
        loop_d    = loop_q;
        len_d     = len_q;
        presc_d   = presc_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        presc_new = presc_ext;

        // Sequence completion drops run; a CPU write in the same cycle
        // overrides it below.
        if (seq_clear_run) begin
            run_d = 1'b0;
        end

        if (reg_wr) begin
            unique case (addr_i)
                A_CTRL: begin
                    run_d  = din_i[0];
                    loop_d = din_i[1];
                end
                A_LEN: begin
                    len_d = din_i[2:0];
                end
                A_PRESC_L: begin
                    presc_new[7:0] = din_i;
                    presc_d        = presc_new[PW-1:0];
                end
                A_PRESC_H: begin
                    presc_new[15:8] = din_i;
                    presc_d         = presc_new[PW-1:0];
                end
                A_PTR: begin
                    ptr_d = din_i[4:0];
                end
                A_DATA: begin
                    ptr_d = ptr_q + 5'd1;
                end
                default: begin
                end
            endcase
        end

        if (reg_rd) begin
            dout_d = rd_data;
            if (addr_i == A_DATA) begin
                ptr_d = ptr_q + 5'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            loop_q  <= 1'b0;
            len_q   <= 3'd0;
            presc_q <= '0;
            ptr_q   <= 5'd0;
            step_q  <= 3'd0;
            pcnt_q  <= '0;
            hold_q  <= 8'd0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            loop_q  <= loop_d;
            len_q   <= len_d;
            presc_q <= presc_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            pcnt_q  <= pcnt_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_wr) begin
            table_mem[ptr_q] <= din_i;
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter: CPU first, then the engine's pending write, else quiet.
    // The engine only ever targets addresses 1..3, so the LED control
    // register at 0xF stays reachable by the CPU alone.
    // -----------------------------------------------------------------------
    always_comb begin
        led_cs_o   = 1'b0;
        led_we_o   = 1'b0;
        led_addr_o = 4'h0;
        led_din_o  = 8'h00;
        if (cpu_led_cs_i) begin
            led_cs_o   = 1'b1;
            led_we_o   = we_i;
            led_addr_o = addr_i;
            led_din_o  = din_i;
        end else if (in_wr) begin
            led_cs_o   = 1'b1;
            led_we_o   = 1'b1;
            led_addr_o = wr_addr;
            led_din_o  = fetch_byte;
        end
    end

    assign dout_o      = dout_q;
    assign busy_o      = busy;
    assign dbg_state_o = state_q;

endmodule
